// File: rtl/placar_pkg.sv
// placar_pkg: FSM states, point values and flat-bus helpers shared by the
// scoreboard core and its BCD converter.
package placar_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, CONVERT} state_t;
  localparam logic [1:0] PTS_UM = 2'd1;
  localparam logic [1:0] PTS_DOIS = 2'd2;
  localparam logic [1:0] PTS_TRES = 2'd3;
  function automatic int field_lsb(input int idx, input int w);
    return idx * w;
  endfunction
  // double-dabble correction applied to one digit before each shift
  function automatic logic [3:0] dabble(input logic [3:0] d);
    return d >= 4'd5 ? d + 4'd3 : d;
  endfunction
endpackage

// File: rtl/bin_para_bcd_seq.sv
// bin_para_bcd_seq: iterative double-dabble, one input bit per cycle; done and
// bcd are valid together in the final shift cycle.
module bin_para_bcd_seq
  import placar_pkg::*;
#(
  parameter int SCORE_W = 7,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  start,
  input  logic [SCORE_W-1:0]    bin,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int SH_W = DIGITS * 4 + SCORE_W;
  logic [SH_W-1:0] sh, sh_nx;
  logic [DIGITS*4-1:0] adj;
  logic [CNT_W-1:0] cnt;
  logic active;
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    assign adj[d*4 +: 4] = dabble(sh[SCORE_W + d*4 +: 4]);
  end
  // binary part and BCD part shift as one register
  assign sh_nx = {adj, sh[SCORE_W-1:0]} << 1;
  assign bcd = sh_nx[SCORE_W +: DIGITS*4];
  assign done = active && cnt == CNT_W'(SCORE_W - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= '0;
      cnt <= '0;
      active <= 1'b0;
    end else if (clr) begin
      active <= 1'b0;
    end else if (start) begin
      sh <= {{(DIGITS*4){1'b0}}, bin};
      cnt <= '0;
      active <= 1'b1;
    end else if (active) begin
      sh <= sh_nx;
      cnt <= cnt + 1'b1;
      active <= !done;
    end
  end
endmodule

// File: rtl/placar_times.sv
// placar_times: basketball scoreboard core; range-checked +/-1..3 updates per
// team followed by a sequential BCD conversion of the updated score.
module placar_times
  import placar_pkg::*;
#(
  parameter int NUM_TIMES = 2,
  parameter int SCORE_W = 7,
  parameter int MAX_SCORE = 99,
  parameter int DIGITS = 2,
  localparam int TSEL_W = $clog2(NUM_TIMES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          btn_um,
  input  logic                          btn_dois,
  input  logic                          btn_tres,
  input  logic                          sub,
  input  logic [TSEL_W-1:0]             sel_time,
  input  logic                          clear,
  output logic [NUM_TIMES*SCORE_W-1:0]  score_flat,
  output logic [NUM_TIMES*DIGITS*4-1:0] bcd_flat,
  output logic                          bcd_valid,
  output logic                          alerta,
  output logic                          busy
);
  localparam int XW = SCORE_W + 1;
  state_t state, state_nx;
  logic [2:0] btn, hist, press;
  logic [1:0] pts_q, pts_in;
  logic sub_q;
  logic [TSEL_W-1:0] sel_q;
  logic [SCORE_W-1:0] score [NUM_TIMES];
  logic [DIGITS*4-1:0] bcd [NUM_TIMES];
  logic [SCORE_W-1:0] cur, new_score;
  logic [XW-1:0] cur_x, pts_x, sum;
  logic multi, single, sel_ok, op_ok, latch, reject, accept, finish, conv_done;
  logic [DIGITS*4-1:0] conv_bcd;
  assign btn = {btn_tres, btn_dois, btn_um};
  assign press = btn & ~hist;
  assign multi = (press[0] & press[1]) | (press[0] & press[2]) | (press[1] & press[2]);
  assign single = |press & ~multi;
  assign pts_in = press[2] ? PTS_TRES : press[1] ? PTS_DOIS : PTS_UM;
  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_TIMES; i++) if (int'(sel_q) == i) cur = score[i];
  end
  // one extra bit so an add past MAX_SCORE cannot wrap before the compare
  assign sel_ok = int'(sel_q) < NUM_TIMES;
  assign cur_x = {1'b0, cur};
  assign pts_x = XW'(pts_q);
  assign sum = cur_x + pts_x;
  assign op_ok = sub_q ? pts_x <= cur_x : sum <= XW'(MAX_SCORE);
  assign new_score = sub_q ? cur - SCORE_W'(pts_q) : cur + SCORE_W'(pts_q);
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    latch = 1'b0;
    reject = 1'b0;
    accept = 1'b0;
    finish = 1'b0;
    if (clear) state_nx = IDLE;
    else
      case (state)
        IDLE: begin
          reject = multi;
          latch = single;
          state_nx = single ? APPLY : IDLE;
        end
        APPLY: begin
          accept = sel_ok & op_ok;
          reject = !(sel_ok & op_ok);
          state_nx = accept ? CONVERT : IDLE;
        end
        CONVERT: begin
          finish = conv_done;
          state_nx = conv_done ? IDLE : CONVERT;
        end
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hist <= '1;
      pts_q <= '0;
      sub_q <= 1'b0;
      sel_q <= '0;
      alerta <= 1'b0;
      bcd_valid <= 1'b0;
      for (int i = 0; i < NUM_TIMES; i++) begin
        score[i] <= '0;
        bcd[i] <= '0;
      end
    end else begin
      state <= state_nx;
      hist <= btn;
      alerta <= reject;
      bcd_valid <= finish;
      if (latch) begin
        pts_q <= pts_in;
        sub_q <= sub;
        sel_q <= sel_time;
      end
      for (int i = 0; i < NUM_TIMES; i++) begin
        if (clear) begin
          score[i] <= '0;
          bcd[i] <= '0;
        end else begin
          if (accept && int'(sel_q) == i) score[i] <= new_score;
          if (finish && int'(sel_q) == i) bcd[i] <= conv_bcd;
        end
      end
    end
  end
  bin_para_bcd_seq #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .start (accept),
    .bin   (new_score),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );
  for (genvar i = 0; i < NUM_TIMES; i++) begin : g_out
    assign score_flat[field_lsb(i, SCORE_W) +: SCORE_W] = score[i];
    assign bcd_flat[field_lsb(i, DIGITS*4) +: DIGITS*4] = bcd[i];
  end
endmodule

// File: tb/tb_placar_times.sv
// tb_placar_times: scoreboard bench; each press pushes its expected outcome,
// the alerta/bcd_valid monitor pops and checks it.
module tb_placar_times;
  localparam int SW = 7;
  logic clk = 1'b0, rst_n = 1'b0;
  logic btn_um = 1'b0, btn_dois = 1'b0, btn_tres = 1'b0, sub = 1'b0, clear = 1'b0;
  logic [0:0] sel_time = '0;
  logic [13:0] score_flat;
  logic [15:0] bcd_flat;
  logic bcd_valid, alerta, busy;
  logic b3_um = 1'b0, b3_tres = 1'b0;
  logic [1:0] sel3 = '0;
  logic [20:0] score3;
  logic [23:0] bcd3;
  logic bv3, al3, busy3;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  int mdl [2] = '{0, 0};
  typedef struct {bit acc; int team; int score; int bcd; int t0; int lat;} exp_t;
  exp_t q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  placar_times dut (
    .clk(clk), .rst_n(rst_n), .btn_um(btn_um), .btn_dois(btn_dois), .btn_tres(btn_tres),
    .sub(sub), .sel_time(sel_time), .clear(clear), .score_flat(score_flat),
    .bcd_flat(bcd_flat), .bcd_valid(bcd_valid), .alerta(alerta), .busy(busy)
  );
  placar_times #(.NUM_TIMES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .btn_um(b3_um), .btn_dois(1'b0), .btn_tres(b3_tres),
    .sub(1'b0), .sel_time(sel3), .clear(1'b0), .score_flat(score3),
    .bcd_flat(bcd3), .bcd_valid(bv3), .alerta(al3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + v % 10;
  endfunction
  function automatic int fld(input int t);
    return int'(score_flat[t*7 +: 7]);
  endfunction
  function automatic int bfld(input int t);
    return int'(bcd_flat[t*8 +: 8]);
  endfunction

  task automatic push_exp(input bit [2:0] m, input int team, input bit s, input int t0);
    exp_t e;
    int pts, nv;
    e.team = team;
    e.t0 = t0;
    e.acc = 1'b0;
    e.lat = 1;
    if ($countones(m) > 1) e.lat = 0;
    else begin
      pts = m[2] ? 3 : m[1] ? 2 : 1;
      nv = s ? mdl[team] - pts : mdl[team] + pts;
      if (nv >= 0 && nv <= 99) begin
        mdl[team] = nv;
        e.acc = 1'b1;
        e.lat = SW + 1;
      end
    end
    e.score = mdl[team];
    e.bcd = to_bcd(mdl[team]);
    q.push_back(e);
  endtask

  task automatic op(input bit [2:0] m, input int team, input bit s, input int hold, input bit push);
    @(posedge clk);
    #1;
    if (push) push_exp(m, team, s, cyc + 1);
    {btn_tres, btn_dois, btn_um} = m;
    sub = s;
    sel_time = 1'(team);
    repeat (hold) @(posedge clk);
    #1 {btn_tres, btn_dois, btn_um} = 3'b000;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("scoreboard drain", q.size(), 0);
      q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (alerta || bcd_valid)) begin
      if (q.size() == 0) begin
        if (alerta) check("unexpected alerta", 1, 0);
        if (bcd_valid) check("unexpected bcd_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("outcome bcd_valid", bcd_valid, e.acc);
        check("outcome alerta", alerta, !e.acc);
        check("pulse latency", cyc - e.t0, e.lat);
        check("score", fld(e.team), e.score);
        if (e.acc) check("bcd", bfld(e.team), e.bcd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset score_flat", score_flat, 0);
    check("reset bcd_flat", bcd_flat, 0);
    check("reset busy", busy, 0);
    check("reset alerta", alerta, 0);
    check("reset bcd_valid", bcd_valid, 0);
    rst_n = 1'b1;
    op(3'b100, 0, 0, 1, 1);
    @(negedge clk);
    check("busy in APPLY", busy, 1);
    @(negedge clk);
    check("score after APPLY edge", fld(0), 3);
    wait_idle();
    for (int i = 0; i < 32; i++) begin
      op(3'b100, 1, 0, 1, 1);
      wait_idle();
    end
    op(3'b010, 1, 0, 1, 1); wait_idle();
    op(3'b010, 1, 0, 1, 1); wait_idle();
    op(3'b100, 1, 0, 1, 1); wait_idle();
    op(3'b001, 1, 0, 1, 1); wait_idle();
    op(3'b010, 0, 1, 1, 1); wait_idle();
    op(3'b010, 0, 1, 1, 1); wait_idle();
    op(3'b001, 0, 1, 1, 1); wait_idle();
    op(3'b001, 0, 1, 1, 1); wait_idle();
    op(3'b010, 0, 0, 20, 1); wait_idle();
    check("held button single press", fld(0), 2);
    op(3'b101, 0, 0, 1, 1); wait_idle();
    op(3'b100, 0, 0, 1, 1);
    repeat (3) @(posedge clk);
    op(3'b001, 0, 0, 1, 0);
    wait_idle();
    check("press in CONVERT ignored", fld(0), mdl[0]);
    op(3'b010, 1, 1, 1, 0);
    repeat (3) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("clear score_flat", score_flat, 0);
    check("clear bcd_flat", bcd_flat, 0);
    check("clear busy", busy, 0);
    mdl = '{0, 0};
    repeat (12) @(posedge clk);
    op(3'b100, 0, 0, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst score_flat", score_flat, 0);
    check("rst bcd_flat", bcd_flat, 0);
    check("rst busy", busy, 0);
    check("rst alerta", alerta, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl = '{0, 0};
    repeat (12) @(posedge clk);
    op(3'b001, 1, 0, 1, 1); wait_idle();
    op(3'b100, 1, 0, 1, 1); wait_idle();
    @(posedge clk);
    #1 b3_um = 1'b1;
    sel3 = 2'd3;
    @(posedge clk);
    #1 b3_um = 1'b0;
    @(negedge clk);
    check("n3 no alerta at press edge", al3, 0);
    @(negedge clk);
    check("n3 illegal team alerta", al3, 1);
    check("n3 scores unchanged", score3, 0);
    @(negedge clk);
    check("n3 alerta one cycle", al3, 0);
    check("n3 busy after reject", busy3, 0);
    @(posedge clk);
    #1 b3_tres = 1'b1;
    sel3 = 2'd2;
    @(posedge clk);
    #1 b3_tres = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("n3 team2 score", score3[20:14], 3);
    check("n3 no alerta on accept", al3, 0);
    repeat (6) @(negedge clk);
    check("n3 bcd_valid not early", bv3, 0);
    @(negedge clk);
    check("n3 bcd_valid", bv3, 1);
    check("n3 team2 bcd", bcd3[23:16], 8'h03);
    check("n3 other bcd", bcd3[15:0], 0);
    repeat (3) @(posedge clk);
    check("queue empty at end", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/placar_times.md
# placar_times

Registered, parametrised basketball scoreboard core. It keeps one score per team and applies +1/+2/+3 or −1/−2/−3 on debounced button rising edges to the selected team. Out-of-range operations are rejected with an alarm pulse instead of wrapping. After each accepted update it converts the new score to BCD sequentially for the 7-segment decoders downstream.

## Interface
- NUM_TIMES, 2, number of teams (≥2)
- SCORE_W, 7, score width in bits
- MAX_SCORE, 99, highest legal score; must be < 2^SCORE_W and ≤ 10^DIGITS−1
- DIGITS, 2, BCD digits per team
- TSEL_W, $clog2(NUM_TIMES), team select width (derived)
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- btn_um, btn_dois, btn_tres  in  1 each  debounced, active-high buttons for 1/2/3 points
- sub  in  1  1 = subtract, 0 = add; sampled with the press
- sel_time  in  TSEL_W  target team; sampled with the press
- clear  in  1  synchronous clear of all scores
- score_flat  out  NUM_TIMES*SCORE_W  binary scores; team i at [i*SCORE_W +: SCORE_W]
- bcd_flat  out  NUM_TIMES*DIGITS*4  BCD scores; team i at [i*DIGITS*4 +: DIGITS*4], LS digit lowest
- bcd_valid  out  1  one-cycle pulse when a BCD update lands
- alerta  out  1  one-cycle pulse on a rejected operation (buzzer/LED)
- busy  out  1  high in APPLY and CONVERT

## Operation
- Reset values: all scores 0, all BCD 0, bcd_valid/alerta/busy 0, FSM IDLE. Button-history registers reset to 1, so a button held through reset gives no press until it is released.
- Press: btn_x high while its history bit is low. History bits update every cycle in every state. Holding a button produces exactly one press.
- FSM states: IDLE, APPLY, CONVERT.
  - IDLE: on a press, latch pts (1/2/3), sub and sel_time, then go to APPLY. If two or more buttons show a press in the same cycle: no latch, pulse alerta, stay in IDLE.
  - APPLY, reject cases (score unchanged, pulse alerta, return to IDLE):
    - sel_time ≥ NUM_TIMES
    - add with score+pts > MAX_SCORE
    - subtract with pts > score
  - APPLY, accept: write score ± pts, then go to CONVERT.
  - CONVERT: iterative double-dabble on the updated team, one bit per cycle, SCORE_W cycles. On the last cycle write that team's BCD field, pulse bcd_valid and go to IDLE.
- Presses arriving in APPLY or CONVERT are dropped silently, with no alerta, but history still tracks them.
- clear has highest priority in every state: zero all scores and BCD, abort any conversion, go to IDLE, no pulses. A press in the same cycle as clear is dropped.
- Arithmetic uses SCORE_W+1 bits internally for overflow checks. Stored scores never exceed MAX_SCORE and never go below 0.

## Timing
- Press sampled at edge t. APPLY runs at t+1, so score_flat and alerta become visible after edge t+1.
- BCD write and bcd_valid occur at edge t+1+SCORE_W (t+8 at defaults).
- Minimum spacing between accepted presses: SCORE_W+2 cycles.
- alerta and bcd_valid are registered pulses, high for exactly one cycle.
- Reset is asynchronous assert and synchronous-safe release. A reset mid-CONVERT discards the conversion; all outputs return to reset values.

## Structure
- Package placar_pkg holds:
  - the state enum (IDLE, APPLY, CONVERT)
  - PTS_UM=1, PTS_DOIS=2, PTS_TRES=3
  - the bit-slice helper functions for the flat buses
- Sub-module bin_para_bcd_seq: start/done iterative converter, parametrised on SCORE_W and DIGITS, one instance shared by all teams.
- The top holds the score register array, edge detection, FSM and range checks.

## Test plan
- Reset, then team 0 add +3 → score_flat[6:0]=3 after 1 edge; bcd_flat team 0 = 0x03 with bcd_valid 8 cycles after the press.
- Team 1 at 98, add +2 → alerta pulse, score stays 98, no bcd_valid. Add +1 → 99, BCD 0x99.
- Team 0 at 1, subtract 2 → alerta, stays 1. Subtract 1 → 0, BCD 0x00.
- Hold btn_dois for 20 cycles → exactly one +2. btn_um and btn_tres rising together → alerta, no change.
- Press during CONVERT → ignored, score unchanged, no alerta. Assert clear mid-CONVERT → all scores and BCD 0, no bcd_valid.
- NUM_TIMES=3, sel_time=3 (illegal) → alerta. Assert rst_n low mid-CONVERT → all outputs 0 and FSM back to IDLE.
